// File: rtl/activation_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : activation_stream_if
// Description : Ready/valid stream of signed activations.
//               master drives data/valid and samples ready;
//               slave samples data/valid and drives ready.
// Ports       : data  [N-1:0] signed activation
//               valid         data is valid this cycle
//               ready         consumer accepts data this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface activation_stream_if #(
  parameter int N = 16
);
  logic signed [N-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/activation_padder.sv
`default_nettype none
// ============================================================================
// Module      : activation_padder
// Description : Takes an MxM raster-order activation matrix and emits an
//               (M+2P)x(M+2P) raster stream with a border of padding around
//               it. Has ready/valid flow control on both sides and pulses
//               done_o when the frame is complete.
// Ports       : clk_i, rst_i      clock, synchronous active-high reset
//               start_i           begins a frame when idle
//               matrix_size_i     unpadded side M (sampled on accepted start)
//               padding_i         padding width P (sampled on accepted start)
//               pad_value_i       pad element value (PADDER_PAD_VALUE_EN only)
//               in_if  (slave)    activation input stream
//               out_if (master)   padded activation output stream
//               busy_o            frame in progress
//               done_o            one-cycle pulse after the last output accept
//               cfg_error_o       sticky flag for a rejected start
// Options     : define PADDER_PAD_VALUE_EN to add pad_value_i; without it
//               pad positions emit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module activation_padder #(
  parameter int MaxMatrixSize = 16383,
  parameter int MaxPadding    = 15,
  parameter int N             = 16
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  input  wire logic                start_i,
  input  wire logic [13:0]         matrix_size_i,
  input  wire logic [3:0]          padding_i,
`ifdef PADDER_PAD_VALUE_EN
  input  wire logic signed [N-1:0] pad_value_i,
`endif
  activation_stream_if.slave       in_if,
  activation_stream_if.master      out_if,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cfg_error_o
);

  localparam int CW = $clog2(MaxMatrixSize + 1);
  // Side arithmetic is two bits wider than both M and the counters so that
  // M+2P can be compared against the limit without wrapping.
  localparam int SW = ((CW > 14) ? CW : 14) + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [3:0]            p_q, p_d;
  logic [SW-1:0]         side_q, side_d;
  logic [SW-1:0]         lim_q, lim_d;      // P+M: first pad index after the interior
  logic signed [N-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  cfg_err_q, cfg_err_d;
  logic signed [N-1:0]   pad_val_w;

  logic [SW-1:0] side_w;
  logic          cfg_ok_w;
  logic [SW-1:0] row_w, col_w;
  logic          interior_w;
  logic          free_w;
  logic          last_col_w, last_row_w;

`ifdef PADDER_PAD_VALUE_EN
  logic signed [N-1:0] pad_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_q <= '0;
    end else if (state_q == S_IDLE && start_i && cfg_ok_w) begin
      pad_q <= pad_value_i;
    end
  end
  assign pad_val_w = pad_q;
`else
  assign pad_val_w = '0;
`endif

  assign side_w   = SW'(matrix_size_i) + SW'({padding_i, 1'b0});
  assign cfg_ok_w = (side_w <= SW'(MaxMatrixSize)) && (SW'(padding_i) <= SW'(MaxPadding));

  assign row_w      = SW'(row_q);
  assign col_w      = SW'(col_q);
  assign interior_w = (row_w >= SW'(p_q)) && (row_w < lim_q) &&
                      (col_w >= SW'(p_q)) && (col_w < lim_q);
  assign free_w     = !valid_q || out_if.ready;
  assign last_col_w = (col_w == side_q - SW'(1));
  assign last_row_w = (row_w == side_q - SW'(1));

  assign in_if.ready = (state_q == S_STREAM) && free_w && interior_w;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign busy_o       = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign cfg_error_o  = cfg_err_q;

  always_comb begin
    logic adv;
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    p_d       = p_q;
    side_d    = side_q;
    lim_d     = lim_q;
    data_d    = data_q;
    // Once the held element is consumed the register empties unless reloaded.
    valid_d   = free_w ? 1'b0 : valid_q;
    cfg_err_d = cfg_err_q;
    adv       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok_w) begin
            p_d       = padding_i;
            side_d    = side_w;
            lim_d     = SW'(matrix_size_i) + SW'(padding_i);
            row_d     = '0;
            col_d     = '0;
            cfg_err_d = 1'b0;
            state_d   = (matrix_size_i == 14'd0) ? S_DONE : S_STREAM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (free_w) begin
          if (!interior_w) begin
            data_d  = pad_val_w;
            valid_d = 1'b1;
            adv     = 1'b1;
          end else if (in_if.valid) begin
            data_d  = in_if.data;
            valid_d = 1'b1;
            adv     = 1'b1;
          end
        end
        if (adv) begin
          if (last_col_w) begin
            col_d = '0;
            if (last_row_w) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_if.ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      p_q       <= '0;
      side_q    <= '0;
      lim_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      p_q       <= p_d;
      side_q    <= side_d;
      lim_q     <= lim_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_activation_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_activation_padder
// Description : Self-checking bench for activation_padder. Stimulus tasks push
//               expected outputs into a scoreboard queue; a monitor pops and
//               compares on every accepted output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_activation_padder;
`ifdef PADDER_PAD_VALUE_EN
  localparam int N = 8;
  localparam logic signed [N-1:0] C_PAD = -8'sd128;
`else
  localparam int N = 16;
  localparam logic signed [N-1:0] C_PAD = '0;
`endif

  typedef logic signed [N-1:0] dat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] msize = '0;
  logic [3:0]  pad = '0;
  logic        busy, done, cfg_err;
`ifdef PADDER_PAD_VALUE_EN
  logic signed [N-1:0] pad_value = C_PAD;
`endif

  activation_stream_if #(.N(N)) in_if ();
  activation_stream_if #(.N(N)) out_if ();

  activation_padder #(.MaxMatrixSize(16383), .MaxPadding(15), .N(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .matrix_size_i(msize),
    .padding_i    (pad),
`ifdef PADDER_PAD_VALUE_EN
    .pad_value_i  (pad_value),
`endif
    .in_if        (in_if),
    .out_if       (out_if),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_error_o  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int out_cnt = 0, acc_cnt = 0, done_cnt = 0, last_acc_cyc = 0;
  int cur_m = 0, cur_p = 0, cur_s = 0;
  bit vgap = 0, rrand = 0, chk_rdy = 0, gap_ph = 0;
  logic [15:0] lfsr = 16'hACE1;
  dat_t exp_q[$];
  dat_t in_vals[$];

  // Scenario 1 hand table: 0 marks a pad position.
  int E1[25] = '{0,0,0,0,0, 0,1,2,3,0, 0,4,5,6,0, 0,7,8,9,0, 0,0,0,0,0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Input driver: drives after the edge, retires an element on handshake.
  initial begin
    in_if.valid = 1'b0;
    in_if.data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (in_vals.size() > 0 && !(vgap && gap_ph)) begin
        in_if.valid = 1'b1;
        in_if.data  = in_vals[0];
      end else begin
        in_if.valid = 1'b0;
        in_if.data  = '0;
      end
      gap_ph = ~gap_ph;
      @(negedge clk);
      if (chk_rdy && busy && in_vals.size() > 0) chk("ready_passthru", int'(in_if.ready), 1);
      if (in_if.valid && in_if.ready && in_vals.size() > 0) begin
        in_vals.delete(0);
        acc_cnt++;
      end
    end
  end

  // Downstream ready: always 1, or a pseudo-random LFSR pattern.
  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        out_if.ready = 1'b0;
      end else if (rrand) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        out_if.ready = lfsr[0];
      end else begin
        out_if.ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   prev_stall;
    dat_t prev_data;
    dat_t ev;
    int   idx, r, c;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          chk("stall_valid_hold", int'(out_if.valid), 1);
          chk("stall_data_hold", int'(out_if.data), int'(prev_data));
        end
        prev_stall = out_if.valid && !out_if.ready;
        prev_data  = out_if.data;
        if (in_if.ready) begin
          idx = out_cnt + (out_if.valid ? 1 : 0);
          r = idx / cur_s;
          c = idx % cur_s;
          chk("ready_only_interior",
              (r >= cur_p && r < cur_p + cur_m && c >= cur_p && c < cur_p + cur_m) ? 1 : 0, 1);
        end
        if (out_if.valid && out_if.ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            ev = exp_q.pop_front();
            chk("data_out", int'(out_if.data), int'(ev));
          end
          out_cnt++;
          last_acc_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          chk("done_all_outputs_seen", exp_q.size(), 0);
          chk("done_busy_low", int'(busy), 0);
          if (cur_m > 0) chk("done_latency", cyc - last_acc_cyc, 1);
        end
      end
    end
  end

  task automatic start_frame(int m, int p);
    @(posedge clk);
    #1;
    start   = 1'b1;
    msize   = m[13:0];
    pad     = p[3:0];
    out_cnt = 0;
    acc_cnt = 0;
    cur_m   = m;
    cur_p   = p;
    cur_s   = m + 2 * p;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) chk({nm, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic frame_totals(string nm);
    chk({nm, "_out_count"}, out_cnt, cur_s * cur_s);
    chk({nm, "_in_count"}, acc_cnt, cur_m * cur_m);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic load_e1();
    for (int i = 1; i <= 9; i++) in_vals.push_back(dat_t'(i));
    for (int i = 0; i < 25; i++) exp_q.push_back((E1[i] == 0) ? C_PAD : dat_t'(E1[i]));
  endtask

  task automatic check_reset_values(string nm);
    chk({nm, "_data_o"}, int'(out_if.data), 0);
    chk({nm, "_valid_o"}, int'(out_if.valid), 0);
    chk({nm, "_ready_o"}, int'(in_if.ready), 0);
    chk({nm, "_busy_o"}, int'(busy), 0);
    chk({nm, "_done_o"}, int'(done), 0);
    chk({nm, "_cfg_error_o"}, int'(cfg_err), 0);
  endtask

  initial begin
    int d0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: M=3 P=1, full-rate.
    load_e1();
    start_frame(3, 1);
    wait_done("s1", 200);
    frame_totals("s1");

    // 2: M=4 P=0 pass-through, inputs -8..7.
    chk_rdy = 1;
    for (int i = -8; i <= 7; i++) begin
      in_vals.push_back(dat_t'(i));
      exp_q.push_back(dat_t'(i));
    end
    start_frame(4, 0);
    wait_done("s2", 200);
    frame_totals("s2");
    chk_rdy = 0;

    // 3: M=5 P=2 with random downstream stalls.
    rrand = 1;
    for (int i = 1; i <= 25; i++) in_vals.push_back(dat_t'(i));
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        exp_q.push_back((r >= 2 && r < 7 && c >= 2 && c < 7) ? dat_t'((r - 2) * 5 + (c - 2) + 1) : C_PAD);
    start_frame(5, 2);
    wait_done("s3", 2000);
    frame_totals("s3");
    rrand = 0;

    // 4: M=3 P=1 with input bubbles.
    vgap = 1;
    load_e1();
    start_frame(3, 1);
    wait_done("s4", 400);
    frame_totals("s4");
    vgap = 0;

    // 5: illegal then legal configuration.
    start_frame(16380, 3);
    @(negedge clk);
    chk("cfg_err_set", int'(cfg_err), 1);
    chk("cfg_err_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("cfg_err_sticky", int'(cfg_err), 1);
    chk("cfg_err_busy_later", int'(busy), 0);
    for (int i = 11; i <= 14; i++) begin
      in_vals.push_back(dat_t'(i));
      exp_q.push_back(dat_t'(i));
    end
    start_frame(2, 0);
    @(negedge clk);
    chk("cfg_err_cleared", int'(cfg_err), 0);
    wait_done("s5", 200);
    frame_totals("s5");

    // 6: M=0 produces only a done pulse.
    d0 = done_cnt;
    start_frame(0, 1);
    wait_done("s6", 20);
    chk("s6_done_count", done_cnt - d0, 1);
    chk("s6_out_count", out_cnt, 0);

    // 7: reset mid-frame, then a clean frame.
    load_e1();
    start_frame(3, 1);
    n = 0;
    while (out_cnt < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s7_reached_10", (out_cnt >= 10) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    in_vals.delete();
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    check_reset_values("s7_abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("s7_no_done", done_cnt - d0, 0);
    load_e1();
    start_frame(3, 1);
    wait_done("s7b", 200);
    frame_totals("s7b");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
